// File: rtl/guvm_wb_pkg.sv
// Shared types and constants for the Wishbone memory responder.
package guvm_wb_pkg;

  // The write-log entry layout follows these widths; the responder's
  // DATA_W/ADR_W parameters must be left at these values.
  localparam int WB_DATA_W = 32;
  localparam int WB_ADR_W  = 32;

  // Returned for a fetch when the instruction queue is empty (ARM mov r0,r0).
  localparam logic [31:0] NOP_INST = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WB_ADR_W-1:0]    adr;
    logic [WB_DATA_W/8-1:0] sel;
    logic [WB_DATA_W-1:0]   dat;
  } wr_entry_t;

endpackage

// File: rtl/guvm_wb_if.sv
// Wishbone B3 classic bus between the core (master) and the responder (slave).
interface guvm_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 32
);
  logic [ADR_W-1:0]    adr;
  logic [DATA_W/8-1:0] sel;
  logic                we;
  logic [DATA_W-1:0]   dat_w;
  logic                cyc;
  logic                stb;
  logic [DATA_W-1:0]   dat_r;
  logic                ack;
  logic                err;

  modport master (
    output adr, sel, we, dat_w, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, sel, we, dat_w, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/guvm_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH is a power of 2, >= 2.
module guvm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Pushes while full and pops while empty are silently ignored.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem[rd_ptr_q];

  // Storage write; contents need no reset since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/guvm_wb_responder.sv
// Wishbone classic slave standing in for memory: fetches from an instruction
// queue, data-region loads from a data queue, writes into a monitor log.
//
//  state | meaning
//  IDLE  | waiting for cyc&stb; request latched on acceptance
//  WAIT  | counting down wait states; cyc or stb low aborts silently
//  RESP  | one-cycle ack (or err if armed); queue pop / log push happen here
module guvm_wb_responder
  import guvm_wb_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              ADR_W      = 32,
  parameter int              INST_DEPTH = 16,
  parameter int              DAT_DEPTH  = 8,
  parameter int              WR_DEPTH   = 8,
  parameter int              WAIT_W     = 3,
  parameter logic [ADR_W-1:0] DATA_BASE = 32'h0001_0000,
  parameter logic [ADR_W-1:0] DATA_MASK = 32'hFFFF_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inst_valid,
  input  logic [DATA_W-1:0]   i_inst_data,
  output logic                o_inst_ready,
  input  logic                i_dat_valid,
  input  logic [DATA_W-1:0]   i_dat_data,
  output logic                o_dat_ready,
  guvm_wb_if.slave            wb,
  output logic                o_wr_valid,
  output logic [ADR_W-1:0]    o_wr_adr,
  output logic [DATA_W/8-1:0] o_wr_sel,
  output logic [DATA_W-1:0]   o_wr_dat,
  input  logic                i_wr_ready,
  input  logic [WAIT_W-1:0]   i_wait_cycles,
  input  logic                i_err_inject,
  output logic                o_inst_uflow,
  output logic                o_dat_uflow,
  output logic                o_wr_oflow,
  output logic [15:0]         o_txn_count
);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q;
  logic                req_we_q, req_data_q;
  logic [ADR_W-1:0]    req_adr_q;
  logic [DATA_W/8-1:0] req_sel_q;
  logic [DATA_W-1:0]   req_dat_q;
  logic                err_arm_q;
  logic [DATA_W-1:0]   dat_hold_q, resp_dat;
  logic                accept, in_resp, resp_ok;
  logic                inst_pop, dat_pop, wr_push;
  logic [DATA_W-1:0]   inst_dout, dat_dout;
  logic                inst_full, inst_empty, dat_full, dat_empty, wr_full, wr_empty;
  wr_entry_t           wr_din, wr_dout;

  assign accept  = (state_q == IDLE) & wb.cyc & wb.stb;
  // A reset landing on the RESP cycle must not ack or pop.
  assign in_resp = (state_q == RESP) & ~rst;
  assign resp_ok = in_resp & ~err_arm_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: abort has priority over the wait-count terminal compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb.cyc && wb.stb) state_d = WAIT;
      WAIT: begin
        if (!(wb.cyc && wb.stb))  state_d = IDLE;
        else if (wcnt_q == '0)    state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response outputs and queue side effects, all confined to RESP.
  always_comb begin
    resp_dat = dat_hold_q;
    inst_pop = 1'b0;
    dat_pop  = 1'b0;
    wr_push  = 1'b0;
    if (resp_ok) begin
      if (req_we_q) begin
        resp_dat = '0;
        wr_push  = 1'b1;
      end else if (req_data_q) begin
        dat_pop  = 1'b1;
        resp_dat = dat_empty ? '0 : dat_dout;
      end else begin
        inst_pop = 1'b1;
        resp_dat = inst_empty ? DATA_W'(NOP_INST) : inst_dout;
      end
    end
  end

  assign wb.ack   = resp_ok;
  assign wb.err   = in_resp & err_arm_q;
  assign wb.dat_r = resp_dat;

  // Wait-state down-counter, loaded on acceptance.
  always_ff @(posedge clk) begin
    if (rst)                                wcnt_q <= '0;
    else if (accept)                        wcnt_q <= i_wait_cycles;
    else if (state_q == WAIT && wcnt_q != '0) wcnt_q <= wcnt_q - WAIT_W'(1);
  end

  // Request capture and region decode at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_we_q   <= 1'b0;
      req_data_q <= 1'b0;
      req_adr_q  <= '0;
      req_sel_q  <= '0;
      req_dat_q  <= '0;
    end else if (accept) begin
      req_we_q   <= wb.we;
      req_data_q <= ((wb.adr & DATA_MASK) == DATA_BASE);
      req_adr_q  <= wb.adr;
      req_sel_q  <= wb.sel;
      req_dat_q  <= wb.dat_w;
    end
  end

  // Read data holds its last driven value between responses.
  always_ff @(posedge clk) begin
    if (rst)          dat_hold_q <= '0;
    else if (in_resp) dat_hold_q <= resp_dat;
  end

  // Error arm: consumed by any RESP, but a pulse in that same cycle re-arms.
  always_ff @(posedge clk) begin
    if (rst) err_arm_q <= 1'b0;
    else     err_arm_q <= i_err_inject | (err_arm_q & ~in_resp);
  end

  // Sticky underflow/overflow flags and completed-transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_inst_uflow <= 1'b0;
      o_dat_uflow  <= 1'b0;
      o_wr_oflow   <= 1'b0;
      o_txn_count  <= '0;
    end else begin
      if (inst_pop & inst_empty) o_inst_uflow <= 1'b1;
      if (dat_pop & dat_empty)   o_dat_uflow  <= 1'b1;
      if (wr_push & wr_full)     o_wr_oflow   <= 1'b1;
      if (in_resp)               o_txn_count  <= o_txn_count + 16'd1;
    end
  end

  assign wr_din       = '{adr: req_adr_q, sel: req_sel_q, dat: req_dat_q};
  assign o_inst_ready = ~inst_full;
  assign o_dat_ready  = ~dat_full;
  assign o_wr_valid   = ~wr_empty;
  assign o_wr_adr     = wr_dout.adr;
  assign o_wr_sel     = wr_dout.sel;
  assign o_wr_dat     = wr_dout.dat;

  guvm_sync_fifo #(.WIDTH(DATA_W), .DEPTH(INST_DEPTH)) u_inst_q (
    .clk(clk), .rst(rst), .push(i_inst_valid), .din(i_inst_data), .pop(inst_pop),
    .dout(inst_dout), .full(inst_full), .empty(inst_empty)
  );

  guvm_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DAT_DEPTH)) u_dat_q (
    .clk(clk), .rst(rst), .push(i_dat_valid), .din(i_dat_data), .pop(dat_pop),
    .dout(dat_dout), .full(dat_full), .empty(dat_empty)
  );

  guvm_sync_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(WR_DEPTH)) u_wr_log (
    .clk(clk), .rst(rst), .push(wr_push), .din(wr_din), .pop(i_wr_ready),
    .dout(wr_dout), .full(wr_full), .empty(wr_empty)
  );

endmodule

// File: tb/tb_guvm_wb_responder.sv
// Directed bench with a response scoreboard for guvm_wb_responder.
module tb_guvm_wb_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_inst_valid, i_dat_valid, i_wr_ready, i_err_inject;
  logic [31:0] i_inst_data, i_dat_data;
  logic        o_inst_ready, o_dat_ready, o_wr_valid;
  logic [31:0] o_wr_adr, o_wr_dat;
  logic [3:0]  o_wr_sel;
  logic [2:0]  i_wait_cycles;
  logic        o_inst_uflow, o_dat_uflow, o_wr_oflow;
  logic [15:0] o_txn_count;

  always #5 clk = ~clk;

  guvm_wb_if #(.DATA_W(32), .ADR_W(32)) wb ();

  guvm_wb_responder dut (
    .clk(clk), .rst(rst),
    .i_inst_valid(i_inst_valid), .i_inst_data(i_inst_data), .o_inst_ready(o_inst_ready),
    .i_dat_valid(i_dat_valid), .i_dat_data(i_dat_data), .o_dat_ready(o_dat_ready),
    .wb(wb),
    .o_wr_valid(o_wr_valid), .o_wr_adr(o_wr_adr), .o_wr_sel(o_wr_sel), .o_wr_dat(o_wr_dat),
    .i_wr_ready(i_wr_ready), .i_wait_cycles(i_wait_cycles), .i_err_inject(i_err_inject),
    .o_inst_uflow(o_inst_uflow), .o_dat_uflow(o_dat_uflow), .o_wr_oflow(o_wr_oflow),
    .o_txn_count(o_txn_count)
  );

  typedef struct {
    bit          err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack/err must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (wb.ack || wb.err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b with none pending at %0t",
                 wb.ack, wb.err, $time);
      end else begin
        e = sb.pop_front();
        chk("resp_ack", 64'(wb.ack), 64'(!e.err));
        chk("resp_err", 64'(wb.err), 64'(e.err));
        if (!e.err) chk("resp_dat", 64'(wb.dat_r), 64'(e.dat));
      end
    end
  end

  task automatic push_inst(input logic [31:0] d);
    i_inst_valid = 1'b1;
    i_inst_data  = d;
    tick();
    i_inst_valid = 1'b0;
  endtask

  task automatic push_dat(input logic [31:0] d);
    i_dat_valid = 1'b1;
    i_dat_data  = d;
    tick();
    i_dat_valid = 1'b0;
  endtask

  task automatic pop_wr();
    i_wr_ready = 1'b1;
    tick();
    i_wr_ready = 1'b0;
  endtask

  // One bus transfer; queues the expected response and checks stb-to-response latency.
  task automatic xfer(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                      input logic [31:0] dat, input bit exp_err, input logic [31:0] exp_dat,
                      input int exp_lat);
    exp_t e;
    int   n;
    e.err = exp_err;
    e.dat = exp_dat;
    sb.push_back(e);
    wb.adr   = adr;
    wb.we    = we;
    wb.sel   = sel;
    wb.dat_w = dat;
    wb.cyc   = 1'b1;
    wb.stb   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(wb.ack || wb.err) && n < 40);
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    wb.we  = 1'b0;
    chk("latency", 64'(n), 64'(exp_lat));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iw [3];
    iw[0] = 32'h1111_1111;
    iw[1] = 32'h2222_2222;
    iw[2] = 32'h3333_3333;
    rst = 1'b1;
    i_inst_valid = 1'b0; i_inst_data = '0;
    i_dat_valid = 1'b0;  i_dat_data = '0;
    i_wr_ready = 1'b0;   i_err_inject = 1'b0;
    i_wait_cycles = 3'd0;
    wb.adr = '0; wb.we = 1'b0; wb.sel = '0; wb.dat_w = '0; wb.cyc = 1'b0; wb.stb = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ack", 64'(wb.ack), 64'd0);
    chk("rst_err", 64'(wb.err), 64'd0);
    chk("rst_dat", 64'(wb.dat_r), 64'd0);
    chk("rst_wr_valid", 64'(o_wr_valid), 64'd0);
    chk("rst_txn", 64'(o_txn_count), 64'd0);
    chk("rst_stickies", 64'({o_inst_uflow, o_dat_uflow, o_wr_oflow}), 64'd0);
    chk("rst_ready", 64'({o_inst_ready, o_dat_ready}), 64'h3);

    // Three fetches, zero wait states
    for (int k = 0; k < 3; k++) push_inst(iw[k]);
    for (int k = 0; k < 3; k++) xfer(32'(4 * k), 1'b0, 4'hF, '0, 1'b0, iw[k], 2);
    chk("txn_after_3", 64'(o_txn_count), 64'd3);

    // Wait states, then an abort in WAIT
    push_inst(32'h4444_4444);
    push_inst(32'h5555_5555);
    i_wait_cycles = 3'd3;
    xfer(32'h10, 1'b0, 4'hF, '0, 1'b0, 32'h4444_4444, 5);
    wb.adr = 32'h14; wb.cyc = 1'b1; wb.stb = 1'b1;
    tick();
    tick();
    wb.cyc = 1'b0; wb.stb = 1'b0;
    repeat (6) tick();
    i_wait_cycles = 3'd0;
    xfer(32'h18, 1'b0, 4'hF, '0, 1'b0, 32'h5555_5555, 2);
    chk("txn_after_abort", 64'(o_txn_count), 64'd5);

    // Region decode
    push_dat(32'hDEAD_BEEF);
    push_inst(32'h6666_6666);
    xfer(32'h0001_0040, 1'b0, 4'hF, '0, 1'b0, 32'hDEAD_BEEF, 2);
    xfer(32'h0000_0040, 1'b0, 4'hF, '0, 1'b0, 32'h6666_6666, 2);

    // Write logging
    xfer(32'h0001_0004, 1'b1, 4'b0011, 32'h1234, 1'b0, 32'h0, 2);
    chk("wr_valid", 64'(o_wr_valid), 64'd1);
    chk("wr_adr", 64'(o_wr_adr), 64'h0001_0004);
    chk("wr_sel", 64'(o_wr_sel), 64'h3);
    chk("wr_dat", 64'(o_wr_dat), 64'h1234);
    pop_wr();
    chk("wr_valid_popped", 64'(o_wr_valid), 64'd0);
    for (int k = 0; k < 9; k++) begin
      xfer(32'h0001_0100 + 32'(4 * k), 1'b1, 4'hF, 32'h100 + 32'(k), 1'b0, 32'h0, 2);
      if (k == 7) chk("wr_oflow_at_full", 64'(o_wr_oflow), 64'd0);
    end
    chk("wr_oflow", 64'(o_wr_oflow), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk("wr_log_dat", 64'(o_wr_dat), 64'(32'h100 + 32'(k)));
      chk("wr_log_adr", 64'(o_wr_adr), 64'(32'h0001_0100 + 32'(4 * k)));
      pop_wr();
    end
    chk("wr_log_drained", 64'(o_wr_valid), 64'd0);

    // Underflow behaviour and reset of stickies
    xfer(32'h0000_0100, 1'b0, 4'hF, '0, 1'b0, 32'hE1A0_0000, 2);
    chk("inst_uflow", 64'(o_inst_uflow), 64'd1);
    xfer(32'h0001_0000, 1'b0, 4'hF, '0, 1'b0, 32'h0, 2);
    chk("dat_uflow", 64'(o_dat_uflow), 64'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("uflow_cleared", 64'({o_inst_uflow, o_dat_uflow, o_wr_oflow}), 64'd0);
    chk("txn_cleared", 64'(o_txn_count), 64'd0);

    // Error injection: err without pop, then the same word is acked
    push_inst(32'h7777_7777);
    i_err_inject = 1'b1;
    tick();
    i_err_inject = 1'b0;
    xfer(32'h20, 1'b0, 4'hF, '0, 1'b1, 32'h0, 2);
    chk("txn_err_counted", 64'(o_txn_count), 64'd1);
    xfer(32'h24, 1'b0, 4'hF, '0, 1'b0, 32'h7777_7777, 2);

    // Maximum wait-state count
    push_inst(32'h8888_8888);
    i_wait_cycles = 3'd7;
    xfer(32'h28, 1'b0, 4'hF, '0, 1'b0, 32'h8888_8888, 9);
    i_wait_cycles = 3'd0;
    chk("txn_final", 64'(o_txn_count), 64'd3);

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
